// File: rtl/cpu_data_pkg.sv
// Shared encodings for the cpu_data_mc datapath: ALU op codes, B-operand sources
// and multiplier FSM states. The multiplier is present only with CPU_DATA_MUL_EN.
package cpu_data_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_LD  = 4'hF;

    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_REG = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;
    localparam logic [1:0] SRC_HI  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/cpu_mul_seq.sv
// Shift-add sequential multiplier, one partial product per cycle for WIDTH cycles.
// Only compiled when CPU_DATA_MUL_EN is defined.
`ifdef CPU_DATA_MUL_EN
module cpu_mul_seq
    import cpu_data_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_e          r_state;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [2*WIDTH-1:0]  r_prod;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  w_prod_next;

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        if (r_mplier[0]) begin
            w_prod_next = r_prod + r_mcand;
        end else begin
            w_prod_next = r_prod;
        end
    end

    // Multiplier FSM: capture operands on start, then shift-add until the last bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state  <= ST_MUL;
                        r_cnt    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, i_a};
                        r_mplier <= i_b;
                        r_prod   <= '0;
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state == ST_MUL);
    assign o_done    = o_busy && (r_cnt == LAST);
    assign o_product = w_prod_next;

endmodule
`endif

// File: rtl/cpu_data_mc.sv
// Accumulator datapath: register file, data memory, ALU with Z/C flags and HI register.
// Define CPU_DATA_MUL_EN to add the multi-cycle multiplier (op E) with BUSY handshake.
module cpu_data_mc
    import cpu_data_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int IWIDTH          = 5,
    parameter int REG_SIZE        = 9,
    parameter int REG_F_SEL_SIZE  = 4,
    parameter int IN_B_SEL_SIZE   = 2,
    parameter int D_MEM_ADDR_SIZE = 8,
    parameter int DMEM_DEPTH      = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [REG_F_SEL_SIZE-1:0]  i_reg_f_sel,
    input  logic                       i_en_reg_f,
    output logic [WIDTH-1:0]           o_port,
    input  logic [D_MEM_ADDR_SIZE-1:0] i_d_mem_addr,
    input  logic                       i_d_mem_addr_mode,
    input  logic                       i_en_d_mem,
    input  logic [IN_B_SEL_SIZE-1:0]   i_in_b_sel,
    input  logic [WIDTH-1:0]           i_imm,
    input  logic [IWIDTH-2:0]          i_alu_out,
    input  logic                       i_en_acc,
    output logic [WIDTH-1:0]           o_acc,
    output logic [WIDTH-1:0]           o_hi,
    output logic                       o_z,
    output logic                       o_c,
    output logic                       o_busy
);

    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]           r_acc;
    logic                       r_z;
    logic                       r_c;
    logic [WIDTH-1:0]           r_regf [REG_SIZE];
    logic [WIDTH-1:0]           r_dmem [DMEM_DEPTH];

    logic                       w_busy;
    logic                       w_mul_done;
    logic [2*WIDTH-1:0]         w_product;
    logic [WIDTH-1:0]           w_hi;
    logic                       w_reg_ok;
    logic                       w_addr_ok;
    logic [D_MEM_ADDR_SIZE-1:0] w_addr;
    logic [WIDTH-1:0]           w_reg_rd;
    logic [WIDTH-1:0]           w_mem_rd;
    logic [WIDTH-1:0]           w_b;
    logic [WIDTH-1:0]           w_result;
    logic [WIDTH:0]             w_sum;
    logic                       w_c_next;
    logic                       w_alu_upd;
    logic                       w_acc_we;
    logic                       w_reg_we;
    logic                       w_mem_we;

`ifdef CPU_DATA_MUL_EN
    logic [WIDTH-1:0] r_hi;
    logic             w_mul_start;

    assign w_mul_start = i_en_acc && !w_busy && (i_alu_out == OP_MUL);

    cpu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_a       (r_acc),
        .i_b       (w_b),
        .o_busy    (w_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // HI captures the upper product half when a multiply completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi <= '0;
        end else if (w_mul_done) begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
        end else begin
            r_hi <= r_hi;
        end
    end

    assign w_hi = r_hi;
`else
    assign w_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_product  = '0;
    assign w_hi       = '0;
`endif

    assign w_reg_ok  = (int'(i_reg_f_sel) < REG_SIZE);
    assign w_addr    = i_d_mem_addr_mode ? D_MEM_ADDR_SIZE'(w_reg_rd) : i_d_mem_addr;
    assign w_addr_ok = (int'(w_addr) < DMEM_DEPTH);

    // Combinational register-file and memory reads; out-of-range selects read zero
    always_comb begin
        if (w_reg_ok) begin
            w_reg_rd = r_regf[i_reg_f_sel];
        end else begin
            w_reg_rd = '0;
        end
        if (w_addr_ok) begin
            w_mem_rd = r_dmem[w_addr];
        end else begin
            w_mem_rd = '0;
        end
    end

    // B-operand source mux
    always_comb begin
        case (i_in_b_sel)
            SRC_IMM: w_b = i_imm;
            SRC_REG: w_b = w_reg_rd;
            SRC_MEM: w_b = w_mem_rd;
            SRC_HI:  w_b = w_hi;
            default: w_b = '0;
        endcase
    end

    // ALU: result, next carry and whether the op commits at all
    always_comb begin
        w_result  = r_acc;
        w_c_next  = r_c;
        w_alu_upd = 1'b0;
        w_sum     = '0;
        case (i_alu_out)
            OP_ADD: begin
                w_sum     = {1'b0, r_acc} + {1'b0, w_b};
                w_result  = w_sum[WIDTH-1:0];
                w_c_next  = w_sum[WIDTH];
                w_alu_upd = 1'b1;
            end
            OP_SUB: begin
                w_result  = r_acc - w_b;
                w_c_next  = (r_acc < w_b);
                w_alu_upd = 1'b1;
            end
            OP_AND: begin
                w_result  = r_acc & w_b;
                w_alu_upd = 1'b1;
            end
            OP_OR: begin
                w_result  = r_acc | w_b;
                w_alu_upd = 1'b1;
            end
            OP_XOR: begin
                w_result  = r_acc ^ w_b;
                w_alu_upd = 1'b1;
            end
            OP_NOT: begin
                w_result  = ~r_acc;
                w_alu_upd = 1'b1;
            end
            OP_SHL: begin
                w_result  = r_acc << 1;
                w_c_next  = r_acc[WIDTH-1];
                w_alu_upd = 1'b1;
            end
            OP_SHR: begin
                w_result  = r_acc >> 1;
                w_c_next  = r_acc[0];
                w_alu_upd = 1'b1;
            end
            OP_INC: begin
                w_sum     = {1'b0, r_acc} + ONE_X;
                w_result  = w_sum[WIDTH-1:0];
                w_c_next  = w_sum[WIDTH];
                w_alu_upd = 1'b1;
            end
            OP_DEC: begin
                w_result  = r_acc - ONE_X[WIDTH-1:0];
                w_c_next  = (r_acc == '0);
                w_alu_upd = 1'b1;
            end
            OP_LD: begin
                w_result  = w_b;
                w_alu_upd = 1'b1;
            end
            default: begin
                w_result  = r_acc;
                w_c_next  = r_c;
                w_alu_upd = 1'b0;
            end
        endcase
    end

    assign w_acc_we = i_en_acc && !w_busy && w_alu_upd;
    assign w_reg_we = i_en_reg_f && !w_busy && w_reg_ok;
    assign w_mem_we = i_en_d_mem && !w_busy && w_addr_ok;

    // Accumulator and flags; a finishing multiply takes priority over ALU commits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_z   <= 1'b1;
            r_c   <= 1'b0;
        end else if (w_mul_done) begin
            r_acc <= w_product[WIDTH-1:0];
            r_z   <= (w_product == '0);
            r_c   <= 1'b0;
        end else if (w_acc_we) begin
            r_acc <= w_result;
            r_z   <= (w_result == '0);
            r_c   <= w_c_next;
        end else begin
            r_acc <= r_acc;
            r_z   <= r_z;
            r_c   <= r_c;
        end
    end

    // Register file stores the pre-edge accumulator
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                r_regf[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regf[i_reg_f_sel] <= r_acc;
        end
    end

    // Data memory is intentionally left unreset
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_dmem[w_addr] <= r_acc;
        end
    end

    assign o_port = r_regf[REG_SIZE-1];
    assign o_acc  = r_acc;
    assign o_hi   = w_hi;
    assign o_z    = r_z;
    assign o_c    = r_c;
    assign o_busy = w_busy;

endmodule
